// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction fetch / load-store) to single-memory-port arbiter.
// Data side has fixed priority; one outstanding transaction with a response timeout.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic        bus_err
);

    typedef enum logic [1:0] {StIdle, StAddr, StResp, StDrain} state_e;
    typedef enum logic {OwnInst = 1'b0, OwnData = 1'b1} owner_e;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

    state_e      state_q;
    owner_e      owner_q;
    logic [15:0] timer_q;
    logic        wr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        in_idle;
    logic        in_resp;
    logic        grant_data;
    logic        grant_inst;
    logic        timeout_hit;
    logic        resp_ok;
    logic        resp_err;
    logic        resp_fire;
    logic [31:0] resp_rdata;

    // Grants are gated by resetn so no output is active while reset is held.
    assign in_idle    = resetn && (state_q == StIdle);
    assign in_resp    = (state_q == StResp);
    assign grant_data = in_idle && data_req;
    assign grant_inst = in_idle && !data_req && inst_req;

    assign timeout_hit = in_resp && (timer_q == TimeoutLast);
    assign resp_ok     = in_resp && mem_data_ok;
    assign resp_err    = timeout_hit && !mem_data_ok;
    assign resp_fire   = resp_ok || resp_err;
    assign resp_rdata  = resp_ok ? mem_rdata : ERR_RDATA;

    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        inst_data_ok = resp_fire && (owner_q == OwnInst);
        data_data_ok = resp_fire && (owner_q == OwnData);
        inst_rdata   = inst_data_ok ? resp_rdata : 32'h0;
        data_rdata   = data_data_ok ? resp_rdata : 32'h0;
        bus_err      = resp_err;
        busy         = (state_q != StIdle);
        mem_req      = (state_q == StAddr);
        mem_wr       = wr_q;
        mem_wstrb    = wstrb_q;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            owner_q <= OwnInst;
            timer_q <= 16'h0;
            wr_q    <= 1'b0;
            wstrb_q <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_data) begin
                        owner_q <= OwnData;
                        wr_q    <= data_wr;
                        wstrb_q <= data_wstrb;
                        addr_q  <= data_addr;
                        wdata_q <= data_wdata;
                        state_q <= StAddr;
                    end else if (grant_inst) begin
                        owner_q <= OwnInst;
                        wr_q    <= 1'b0;
                        wstrb_q <= 4'h0;
                        addr_q  <= inst_addr;
                        wdata_q <= 32'h0;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (mem_addr_ok) begin
                        timer_q <= 16'h0;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    timer_q <= timer_q + 16'd1;
                    if (resp_ok) begin
                        state_q <= StIdle;
                    end else if (resp_err) begin
                        // The late response is still owed by memory; swallow it.
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (mem_data_ok) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    a_addr_ok_excl: assert property (@(posedge clk) disable iff (!resetn)
        !(inst_addr_ok && data_addr_ok));
    a_data_ok_excl: assert property (@(posedge clk) disable iff (!resetn)
        !(inst_data_ok && data_data_ok));
    a_req_stable: assert property (@(posedge clk) disable iff (!resetn)
        (mem_req && !mem_addr_ok) |=> (mem_req && $stable(mem_addr) && $stable(mem_wr)
                                       && $stable(mem_wstrb) && $stable(mem_wdata)));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected responses are queued at grant time
// and checked by a negedge monitor; cycle-level behaviour is checked inline.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, bus_err;

    typedef struct packed {
        logic        owner;  // 1 = data side
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT_CYC(4),
        .ERR_RDATA  (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .bus_err     (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clr();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    task automatic push(input logic owner, input logic [31:0] rdata, input logic err);
        exp_t x;
        x.owner = owner;
        x.rdata = rdata;
        x.err   = err;
        sb.push_back(x);
    endtask

    // Response monitor: every data_ok must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            chk1("addr_ok_excl", inst_addr_ok && data_addr_ok, 1'b0);
            chk1("data_ok_excl", inst_data_ok && data_data_ok, 1'b0);
            if (inst_data_ok || data_data_ok) begin
                if (sb.size() == 0) begin
                    check("stray_data_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk1("resp_owner", data_data_ok, e.owner);
                    check("resp_rdata", e.owner ? data_rdata : inst_rdata, e.rdata);
                    check("resp_other_rdata", e.owner ? inst_rdata : data_rdata, 32'h0);
                    chk1("resp_err", bus_err, e.err);
                end
            end else begin
                chk1("quiet_bus_err", bus_err, 1'b0);
                check("quiet_rdata", inst_rdata | data_rdata, 32'h0);
            end
        end
    end

    initial begin
        resetn     = 1'b0;
        clr();
        inst_req   = 1'b1;
        inst_addr  = 32'h0;
        data_wr    = 1'b0;
        data_wstrb = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        #3;
        chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_bus_err", bus_err, 1'b0);
        smp();
        cyc();
        inst_req = 1'b0;
        resetn   = 1'b1;
        mon_en   = 1'b1;

        // Minimum-latency load
        cyc();
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = 32'h1C00_0100;
        push(1'b1, 32'h1234_5678, 1'b0);
        smp();
        chk1("t1_data_addr_ok", data_addr_ok, 1'b1);
        chk1("t1_mem_req_n", mem_req, 1'b0);
        cyc();
        data_req    = 1'b0;
        mem_addr_ok = 1'b1;
        smp();
        chk1("t1_mem_req_n1", mem_req, 1'b1);
        chk1("t1_mem_wr", mem_wr, 1'b0);
        check("t1_mem_addr", mem_addr, 32'h1C00_0100);
        chk1("t1_busy", busy, 1'b1);
        cyc();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1234_5678;
        smp();
        chk1("t1_data_data_ok_n2", data_data_ok, 1'b1);
        cyc();
        clr();
        smp();
        chk1("t1_idle", busy, 1'b0);

        // Simultaneous requests: data store wins, fetch follows
        cyc();
        inst_req   = 1'b1;
        inst_addr  = 32'h1C00_0000;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h0000_0008;
        data_wdata = 32'hA5A5_A5A5;
        push(1'b1, 32'h0, 1'b0);
        smp();
        chk1("t2_data_first", data_addr_ok, 1'b1);
        cyc();
        data_req    = 1'b0;
        mem_addr_ok = 1'b1;
        smp();
        chk1("t2_mem_wr", mem_wr, 1'b1);
        check("t2_mem_wstrb", {28'h0, mem_wstrb}, 32'h3);
        check("t2_mem_addr", mem_addr, 32'h8);
        check("t2_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk1("t2_inst_wait_addr", inst_addr_ok, 1'b0);
        cyc();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        smp();
        chk1("t2_store_done", data_data_ok, 1'b1);
        chk1("t2_inst_wait_resp", inst_addr_ok, 1'b0);
        cyc();
        mem_data_ok = 1'b0;
        push(1'b0, 32'h0BAD_F00D, 1'b0);
        smp();
        chk1("t2_inst_grant", inst_addr_ok, 1'b1);
        cyc();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b1;
        smp();
        chk1("t2_inst_mem_wr", mem_wr, 1'b0);
        check("t2_inst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("t2_inst_mem_addr", mem_addr, 32'h1C00_0000);
        cyc();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0BAD_F00D;
        smp();
        chk1("t2_inst_data_ok", inst_data_ok, 1'b1);
        cyc();
        clr();

        // Address phase stalled 5 cycles; timer must not run during it
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_addr  = 32'h0000_0040;
        data_wstrb = 4'h0;
        push(1'b1, 32'h55AA_55AA, 1'b0);
        smp();
        chk1("t3_grant", data_addr_ok, 1'b1);
        cyc();
        data_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            mem_addr_ok = (i == 5);
            smp();
            chk1("t3_mem_req_held", mem_req, 1'b1);
            check("t3_mem_addr_held", mem_addr, 32'h40);
        end
        cyc();
        mem_addr_ok = 1'b0;
        smp();
        chk1("t3_resp1_none", data_data_ok, 1'b0);
        cyc();
        smp();
        chk1("t3_resp2_none", data_data_ok, 1'b0);
        cyc();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h55AA_55AA;
        smp();
        chk1("t3_resp3_data", data_data_ok, 1'b1);
        cyc();
        clr();

        // Timeout on a fetch, then drain the late response
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0100;
        push(1'b0, 32'hDEAD_BEEF, 1'b1);
        smp();
        chk1("t4_grant", inst_addr_ok, 1'b1);
        cyc();
        mem_addr_ok = 1'b1;
        smp();
        chk1("t4_mem_req", mem_req, 1'b1);
        cyc();
        mem_addr_ok = 1'b0;
        inst_addr   = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            smp();
            chk1("t4_resp_data_ok", inst_data_ok, i == 3);
            chk1("t4_resp_bus_err", bus_err, i == 3);
            chk1("t4_resp_no_grant", inst_addr_ok, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            smp();
            chk1("t4_drain_no_grant", inst_addr_ok, 1'b0);
            chk1("t4_drain_busy", busy, 1'b1);
        end
        cyc();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0000_0077;
        smp();
        chk1("t4_discard_no_data_ok", inst_data_ok, 1'b0);
        chk1("t4_discard_no_grant", inst_addr_ok, 1'b0);

        // Response arriving in the timeout cycle wins
        cyc();
        mem_data_ok = 1'b0;
        push(1'b0, 32'hCAFE_0001, 1'b0);
        smp();
        chk1("t5_grant_after_drain", inst_addr_ok, 1'b1);
        cyc();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b1;
        smp();
        check("t5_mem_addr", mem_addr, 32'h200);
        cyc();
        mem_addr_ok = 1'b0;
        mem_rdata   = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            mem_data_ok = (i == 3);
            smp();
            chk1("t5_data_ok", inst_data_ok, i == 3);
            chk1("t5_no_bus_err", bus_err, 1'b0);
        end
        cyc();
        clr();
        smp();
        chk1("t5_back_idle", busy, 1'b0);

        // Reset during the response phase abandons the transaction
        cyc();
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = 32'h0000_0300;
        smp();
        chk1("t6_grant", data_addr_ok, 1'b1);
        cyc();
        data_req    = 1'b0;
        mem_addr_ok = 1'b1;
        smp();
        cyc();
        mem_addr_ok = 1'b0;
        smp();
        chk1("t6_in_resp", busy, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk1("t6_async_busy", busy, 1'b0);
        chk1("t6_async_mem_req", mem_req, 1'b0);
        check("t6_async_mem_addr", mem_addr, 32'h0);
        chk1("t6_async_data_ok", data_data_ok, 1'b0);
        cyc();
        resetn      = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0000_0099;
        smp();
        chk1("t6_stray_data_ok", data_data_ok, 1'b0);
        chk1("t6_stray_busy", busy, 1'b0);
        cyc();
        mem_data_ok = 1'b0;
        smp();
        chk1("t6_still_idle", busy, 1'b0);

        check("sb_drained", sb.size(), 32'h0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
